// File: rtl/baseline_pkg.sv
// Shared encodings, tracker state type and width helper for baseline_tracker.
package baseline_pkg;

    // Each stream lane is 16 bits wide; the ADC sample sits in its low bits.
    localparam int unsigned LANE_W = 16;

    // EXEC_STATE encodings; anything other than INIT holds the baseline.
    localparam logic [1:0] EXEC_INIT = 2'b00;
    localparam logic [1:0] EXEC_TRG  = 2'b11;

    typedef enum logic [1:0] {
        ST_ACQ    = 2'd0,
        ST_TRACK  = 2'd1,
        ST_FROZEN = 2'd2
    } bl_state_t;

    // Ceiling log2; clogb2(1) = 0.
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/baseline_tracker_word_sum.sv
// Sign-extends the sample of every lane and registers the sum across lanes.
module word_sum
    import baseline_pkg::*;
#(
    parameter int unsigned LANES = 8,
    parameter int unsigned ADC_W = 12,
    parameter int unsigned SUM_W = 15
) (
    input  logic                    AXIS_ACLK,
    input  logic                    AXIS_ARESET,
    input  logic                    clr,
    input  logic                    in_vld,
    input  logic [LANES*LANE_W-1:0] in_data,
    output logic                    out_vld,
    output logic signed [SUM_W-1:0] out_sum
);

    logic signed [SUM_W-1:0] sum_c;
    logic                    unused_hi;

    // Lane adder; bits above the sample in each lane are ignored.
    always_comb begin
        sum_c     = '0;
        unused_hi = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            sum_c     = sum_c + SUM_W'($signed(in_data[i*LANE_W +: ADC_W]));
            unused_hi = unused_hi ^ (^in_data[i*LANE_W + ADC_W +: LANE_W - ADC_W]);
        end
    end

    // Single register stage; a restart drops the word in flight.
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            out_vld <= 1'b0;
            out_sum <= '0;
        end else if (clr) begin
            out_vld <= 1'b0;
        end else begin
            out_vld <= in_vld;
            if (in_vld) begin
                out_sum <= sum_c;
            end
        end
    end

endmodule

// File: rtl/baseline_tracker.sv
// ADC baseline estimator: block-average acquisition, then shift-based EMA
// tracking with outlier rejection, frozen while the trigger is active.
module baseline_tracker
    import baseline_pkg::*;
#(
    parameter int unsigned ADC_RESOLUTION_WIDTH = 12,
    parameter int unsigned S_AXIS_TDATA_WIDTH   = 128,
    parameter int unsigned ACQ_LEN_LOG2         = 20,
    parameter int unsigned EMA_SHIFT            = 6,
    parameter int unsigned REJECT_CNT_WIDTH     = 16
) (
    input  logic                                   AXIS_ACLK,
    input  logic                                   AXIS_ARESET,
    input  logic [1:0]                             EXEC_STATE,
    input  logic [S_AXIS_TDATA_WIDTH-1:0]          S_AXIS_TDATA,
    input  logic                                   S_AXIS_TVALID,
    input  logic                                   I_TRACK_EN,
    input  logic                                   I_RESTART,
    input  logic [ADC_RESOLUTION_WIDTH-1:0]        I_REJECT_THRESH,
    output logic signed [ADC_RESOLUTION_WIDTH-1:0] O_BASELINE,
    output logic                                   O_CALC_COMPLETE,
    output logic                                   O_UPDATE,
    output logic [REJECT_CNT_WIDTH-1:0]            O_REJECT_CNT
);

    localparam int unsigned ADC_W    = ADC_RESOLUTION_WIDTH;
    localparam int unsigned SPW      = S_AXIS_TDATA_WIDTH / LANE_W;
    localparam int unsigned SPW_LOG2 = clogb2(SPW);
    localparam int unsigned SUM_W    = ADC_W + SPW_LOG2;
    localparam int unsigned ACC_W    = SUM_W + ACQ_LEN_LOG2;
    localparam int unsigned CNT_W    = ACQ_LEN_LOG2 + 1;
    localparam int unsigned FX_W     = ADC_W + EMA_SHIFT + 1;
    localparam int unsigned DIFF_W   = ADC_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = {1'b0, {ACQ_LEN_LOG2{1'b1}}};

    bl_state_t                    state, state_nxt;
    logic                         accept;
    logic [CNT_W-1:0]             word_cnt;

    logic                         s0_vld, s0_trk, s0_last;
    logic [S_AXIS_TDATA_WIDTH-1:0] s0_data;
    logic                         s1_vld, s1_trk, s1_last;
    logic signed [SUM_W-1:0]      s1_sum;
    logic signed [ADC_W-1:0]      s1_mean;
    logic signed [DIFF_W-1:0]     s1_diff;
    logic [DIFF_W-1:0]            s1_dev;
    logic                         s1_rej;

    logic                         s2_vld, s2_trk, s2_last, s2_rej;
    logic signed [ADC_W-1:0]      s2_mean;
    logic signed [ACC_W-1:0]      acc;
    logic signed [ADC_W-1:0]      acq_res;
    logic signed [FX_W-1:0]       bl_fx, fx_init, fx_ema;

    // Acceptance and next-state decode; restart overrides everything.
    always_comb begin
        accept    = S_AXIS_TVALID && (EXEC_STATE == EXEC_INIT) &&
                    ((state == ST_ACQ) || (state == ST_TRACK)) && !I_RESTART;
        state_nxt = state;
        if (I_RESTART) begin
            state_nxt = ST_ACQ;
        end else begin
            case (state)
                ST_ACQ:    if (accept && (word_cnt == LAST_IDX))
                               state_nxt = I_TRACK_EN ? ST_TRACK : ST_FROZEN;
                ST_TRACK:  if (!I_TRACK_EN) state_nxt = ST_FROZEN;
                ST_FROZEN: if (I_TRACK_EN)  state_nxt = ST_TRACK;
                default:   state_nxt = ST_ACQ;
            endcase
        end
    end

    // State register.
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) state <= ST_ACQ;
        else             state <= state_nxt;
    end

    // Input capture and acquisition word counter; each word is tagged with its role.
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            s0_vld   <= 1'b0;
            s0_trk   <= 1'b0;
            s0_last  <= 1'b0;
            s0_data  <= '0;
            word_cnt <= '0;
        end else if (I_RESTART) begin
            s0_vld   <= 1'b0;
            word_cnt <= '0;
        end else begin
            s0_vld <= accept;
            if (accept) begin
                s0_data <= S_AXIS_TDATA;
                s0_trk  <= (state == ST_TRACK);
                s0_last <= (state == ST_ACQ) && (word_cnt == LAST_IDX);
                if (state == ST_ACQ) word_cnt <= word_cnt + CNT_W'(1);
            end
        end
    end

    word_sum #(
        .LANES (SPW),
        .ADC_W (ADC_W),
        .SUM_W (SUM_W)
    ) u_word_sum (
        .AXIS_ACLK   (AXIS_ACLK),
        .AXIS_ARESET (AXIS_ARESET),
        .clr         (I_RESTART),
        .in_vld      (s0_vld),
        .in_data     (s0_data),
        .out_vld     (s1_vld),
        .out_sum     (s1_sum)
    );

    // Role tags travel alongside the word sum.
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            s1_trk  <= 1'b0;
            s1_last <= 1'b0;
        end else if (s0_vld) begin
            s1_trk  <= s0_trk;
            s1_last <= s0_last;
        end
    end

    // Word mean (floor) and deviation check against the current output baseline.
    always_comb begin
        s1_mean = s1_sum[SPW_LOG2 +: ADC_W];
        s1_diff = DIFF_W'(s1_mean) - DIFF_W'(O_BASELINE);
        s1_dev  = s1_diff[DIFF_W-1] ? -s1_diff : s1_diff;
        s1_rej  = (I_REJECT_THRESH != '0) && (s1_dev > {1'b0, I_REJECT_THRESH});
    end

    // Acquisition accumulator and compare-result register.
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            s2_vld  <= 1'b0;
            s2_trk  <= 1'b0;
            s2_last <= 1'b0;
            s2_rej  <= 1'b0;
            s2_mean <= '0;
            acc     <= '0;
        end else if (I_RESTART) begin
            s2_vld <= 1'b0;
            acc    <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_trk  <= s1_trk;
                s2_last <= s1_last;
                s2_rej  <= s1_rej;
                s2_mean <= s1_mean;
                if (!s1_trk) acc <= acc + ACC_W'(s1_sum);
            end
        end
    end

    // Block-average result and EMA step.
    always_comb begin
        acq_res = acc[SPW_LOG2 + ACQ_LEN_LOG2 +: ADC_W];
        fx_init = FX_W'(acq_res) <<< EMA_SHIFT;
        fx_ema  = bl_fx + FX_W'(s2_mean) - (bl_fx >>> EMA_SHIFT);
    end

    // Output register: acquisition result, EMA update or reject count.
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            O_BASELINE      <= '0;
            O_CALC_COMPLETE <= 1'b0;
            O_UPDATE        <= 1'b0;
            O_REJECT_CNT    <= '0;
            bl_fx           <= '0;
        end else if (I_RESTART) begin
            O_CALC_COMPLETE <= 1'b0;
            O_UPDATE        <= 1'b0;
            O_REJECT_CNT    <= '0;
        end else begin
            O_UPDATE <= 1'b0;
            if (s2_vld) begin
                if (!s2_trk) begin
                    if (s2_last) begin
                        O_BASELINE      <= acq_res;
                        bl_fx           <= fx_init;
                        O_CALC_COMPLETE <= 1'b1;
                        O_UPDATE        <= 1'b1;
                    end
                end else if (s2_rej) begin
                    if (O_REJECT_CNT != '1) O_REJECT_CNT <= O_REJECT_CNT + REJECT_CNT_WIDTH'(1);
                end else begin
                    bl_fx      <= fx_ema;
                    O_BASELINE <= fx_ema[EMA_SHIFT +: ADC_W];
                    O_UPDATE   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_baseline_tracker.sv
// Bench for baseline_tracker: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based behavioural model.
module tb_baseline_tracker;

    localparam int ADC_W     = 12;
    localparam int TDW       = 128;
    localparam int SPW       = 8;
    localparam int SPW_LOG2  = 3;
    localparam int ACQ_LOG2  = 4;
    localparam int ACQ_WORDS = 1 << ACQ_LOG2;
    localparam int K         = 2;
    localparam int RCW       = 3;
    localparam logic [1:0] INIT = 2'b00;
    localparam logic [1:0] TRG  = 2'b11;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [1:0]              exec_st;
    logic [TDW-1:0]          tdata;
    logic                    tvalid, track_en, restart;
    logic [ADC_W-1:0]        thresh;
    logic signed [ADC_W-1:0] bl;
    logic                    comp, upd;
    logic [RCW-1:0]          rcnt;

    always #5 clk = ~clk;

    baseline_tracker #(
        .ADC_RESOLUTION_WIDTH (ADC_W),
        .S_AXIS_TDATA_WIDTH   (TDW),
        .ACQ_LEN_LOG2         (ACQ_LOG2),
        .EMA_SHIFT            (K),
        .REJECT_CNT_WIDTH     (RCW)
    ) dut (
        .AXIS_ACLK       (clk),
        .AXIS_ARESET     (rst),
        .EXEC_STATE      (exec_st),
        .S_AXIS_TDATA    (tdata),
        .S_AXIS_TVALID   (tvalid),
        .I_TRACK_EN      (track_en),
        .I_RESTART       (restart),
        .I_REJECT_THRESH (thresh),
        .O_BASELINE      (bl),
        .O_CALC_COMPLETE (comp),
        .O_UPDATE        (upd),
        .O_REJECT_CNT    (rcnt)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int t;
        bit trk;
        bit last;
        int m;
        int res;
        bit rej;
    } item_t;

    item_t q[$];
    int    m_state;   // 0 acquiring, 1 tracking, 2 frozen
    int    m_cnt, m_bl, m_fx, m_rc, cyc;
    longint m_acc;
    bit    m_comp, m_upd;

    function automatic int lane_val(input logic [TDW-1:0] d, input int i);
        int v;
        v = int'(d[i*16 +: ADC_W]);
        if (v >= (1 << (ADC_W-1))) v -= (1 << ADC_W);
        return v;
    endfunction

    function automatic int word_total(input logic [TDW-1:0] d);
        int s;
        s = 0;
        for (int i = 0; i < SPW; i++) s += lane_val(d, i);
        return s;
    endfunction

    always @(posedge clk or posedge rst) begin
        int    ps, dv, s;
        item_t it;
        if (rst) begin
            q.delete();
            m_state = 0; m_cnt = 0; m_acc = 0; m_bl = 0; m_fx = 0; m_rc = 0;
            m_comp = 0; m_upd = 0; cyc = 0;
        end else begin
            ps    = m_state;
            m_upd = 0;
            if (restart) begin
                q.delete();
                m_acc = 0; m_cnt = 0; m_comp = 0; m_rc = 0; m_state = 0;
            end else begin
                // deviation is judged against the baseline visible two edges after acceptance
                foreach (q[i]) begin
                    if (q[i].trk && q[i].t == cyc - 2) begin
                        dv = q[i].m - m_bl;
                        if (dv < 0) dv = -dv;
                        q[i].rej = (thresh != 0) && (dv > int'(thresh));
                    end
                end
                if (q.size() > 0 && q[0].t == cyc - 3) begin
                    it = q.pop_front();
                    if (!it.trk) begin
                        if (it.last) begin
                            m_bl = it.res; m_fx = it.res * (1 << K); m_comp = 1; m_upd = 1;
                        end
                    end else if (it.rej) begin
                        if (m_rc < (1 << RCW) - 1) m_rc++;
                    end else begin
                        m_fx = m_fx + it.m - (m_fx >>> K);
                        m_bl = m_fx >>> K;
                        m_upd = 1;
                    end
                end
                if (tvalid && exec_st == INIT && (ps == 0 || ps == 1)) begin
                    s = word_total(tdata);
                    it = '{t: cyc, trk: (ps == 1), last: 0, m: (s >>> SPW_LOG2), res: 0, rej: 0};
                    if (ps == 0) begin
                        m_acc += s;
                        m_cnt++;
                        if (m_cnt == ACQ_WORDS) begin
                            it.last = 1;
                            it.res  = int'(m_acc >>> (SPW_LOG2 + ACQ_LOG2));
                            m_state = track_en ? 1 : 2;
                        end
                    end
                    q.push_back(it);
                end
                if (ps == 1 && !track_en) m_state = 2;
                else if (ps == 2 && track_en) m_state = 1;
            end
            cyc++;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("baseline", bl, m_bl);
            check("calc_complete", comp, m_comp);
            check("update", upd, m_upd);
            check("reject_cnt", rcnt, m_rc);
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [TDW-1:0] pack2(input int even_v, input int odd_v);
        logic [TDW-1:0] w;
        logic [15:0]    lane;
        w = '0;
        for (int i = 0; i < SPW; i++) begin
            lane        = 16'(((i % 2) == 0) ? even_v : odd_v);
            lane[15:12] = 4'($urandom);
            w[i*16 +: 16] = lane;
        end
        return w;
    endfunction

    function automatic logic [TDW-1:0] pack_rand(input int base, input int spread, input bit outlier);
        logic [TDW-1:0] w;
        logic [15:0]    lane;
        int             v;
        w = '0;
        for (int i = 0; i < SPW; i++) begin
            v = base + int'($urandom_range(0, 2*spread)) - spread;
            if (outlier) v += 700;
            if (v > 2047) v = 2047;
            if (v < -2048) v = -2048;
            lane        = 16'(v);
            lane[15:12] = 4'($urandom);
            w[i*16 +: 16] = lane;
        end
        return w;
    endfunction

    task automatic drive(input bit v, input logic [1:0] es, input logic [TDW-1:0] d, input bit rs);
        tvalid  = v;
        exec_st = es;
        tdata   = d;
        restart = rs;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, INIT, '0, 1'b0);
    endtask

    task automatic acquire(input int v);
        drive(1'b0, INIT, '0, 1'b1);
        for (int i = 0; i < ACQ_WORDS; i++) drive(1'b1, INIT, pack2(v, v), 1'b0);
        idle(4);
    endtask

    // ---------------- directed and random scenarios ----------------
    initial begin
        int ema_exp[3];
        int got;
        int base;
        ema_exp = '{125, 143, 158};
        tvalid = 0; exec_st = INIT; tdata = '0; restart = 0; track_en = 1; thresh = '0;

        repeat (3) @(negedge clk);
        check("reset_baseline", bl, 0);
        check("reset_complete", comp, 0);
        check("reset_update", upd, 0);
        check("reset_rejcnt", rcnt, 0);
        rst = 0;
        chk_en = 1;

        // constant 100, completion latency of three edges
        for (int i = 0; i < ACQ_WORDS; i++) drive(1'b1, INIT, pack2(100, 100), 1'b0);
        idle(2);
        check("complete_not_early", comp, 0);
        idle(1);
        check("acq_baseline_100", bl, 100);
        check("acq_complete", comp, 1);
        check("acq_update_pulse", upd, 1);
        idle(1);
        check("update_one_cycle", upd, 0);

        // EMA steps towards 200
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, INIT, pack2(200, 200), 1'b0);
            idle(3);
            check("ema_step", bl, ema_exp[i]);
            check("ema_update", upd, 1);
        end

        // rejection and counter saturation
        acquire(100);
        thresh = 12'd50;
        for (int i = 0; i < 5; i++) drive(1'b1, INIT, pack2(1000, 1000), 1'b0);
        idle(4);
        check("reject_hold_baseline", bl, 100);
        check("reject_count_5", rcnt, 5);
        for (int i = 0; i < 4; i++) drive(1'b1, INIT, pack2(1000, 1000), 1'b0);
        idle(4);
        check("reject_count_sat", rcnt, 7);
        thresh = '0;

        // negative floor: -4.5 -> -5
        acquire(0);
        drive(1'b0, INIT, '0, 1'b1);
        for (int i = 0; i < ACQ_WORDS; i++) drive(1'b1, INIT, pack2(-5, -4), 1'b0);
        idle(3);
        check("floor_negative", bl, -5);
        idle(1);

        // hold and TVALID gaps during acquisition, frozen afterwards
        track_en = 0;
        drive(1'b0, INIT, '0, 1'b1);
        got = 0;
        for (int c = 0; c < 200 && got < 8; c++) begin
            if ($urandom_range(0, 2) != 0) begin drive(1'b1, INIT, pack2(40, 40), 1'b0); got++; end
            else drive(1'b0, INIT, pack2(2000, 2000), 1'b0);
        end
        for (int i = 0; i < 8; i++) drive(1'b1, (i % 3 == 0) ? 2'b01 : TRG, pack2(2000, 2000), 1'b0);
        for (int c = 0; c < 200 && got < ACQ_WORDS; c++) begin
            if ($urandom_range(0, 2) != 0) begin drive(1'b1, INIT, pack2(60, 60), 1'b0); got++; end
            else drive(1'b0, INIT, pack2(-2000, -2000), 1'b0);
        end
        check("hold_word_count", got, ACQ_WORDS);
        idle(2);
        check("hold_not_early", comp, 0);
        idle(1);
        check("hold_complete", comp, 1);
        check("hold_result", bl, 50);
        for (int i = 0; i < 4; i++) drive(1'b1, INIT, pack2(900, 900), 1'b0);
        idle(4);
        check("frozen_ignores", bl, 50);
        track_en = 1;

        // asynchronous reset in the middle of tracking
        acquire(300);
        drive(1'b1, INIT, pack2(310, 310), 1'b0);
        idle(1);
        @(posedge clk);
        #2 rst = 1;
        #1;
        check("async_rst_baseline", bl, 0);
        check("async_rst_complete", comp, 0);
        check("async_rst_update", upd, 0);
        check("async_rst_rejcnt", rcnt, 0);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < ACQ_WORDS - 1; i++) drive(1'b1, INIT, pack2(77, 77), 1'b0);
        idle(4);
        check("rst_needs_full_acq", comp, 0);
        drive(1'b1, INIT, pack2(77, 77), 1'b0);
        idle(3);
        check("rst_reacquire", bl, 77);
        idle(1);

        // restart coincident with the final acquisition word
        drive(1'b0, INIT, '0, 1'b1);
        for (int i = 0; i < ACQ_WORDS - 1; i++) drive(1'b1, INIT, pack2(-30, -30), 1'b0);
        drive(1'b1, INIT, pack2(-30, -30), 1'b1);
        idle(5);
        check("restart_wins", comp, 0);
        check("restart_keeps_baseline", bl, 77);

        // randomized traffic
        base = 0;
        for (int c = 0; c < 4000; c++) begin
            bit rs;
            logic [1:0] es;
            rs = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 99) == 0) track_en = ~track_en;
            if ($urandom_range(0, 199) == 0) begin
                case ($urandom_range(0, 3))
                    0:       thresh = 12'd0;
                    1:       thresh = 12'd20;
                    2:       thresh = 12'd100;
                    default: thresh = 12'd400;
                endcase
            end
            if (rs) base = int'($urandom_range(0, 3000)) - 1500;
            if ($urandom_range(0, 29) == 0) base += int'($urandom_range(0, 80)) - 40;
            es = ($urandom_range(0, 6) == 0) ? 2'($urandom) : INIT;
            drive($urandom_range(0, 3) != 0, es, pack_rand(base, 20, $urandom_range(0, 19) == 0), rs);
        end
        idle(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
